// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES decryption round datapath:
// FSM state encoding, the FIPS-197 inverse S-box table and state byte addressing.
package aes_dec_pkg;

    localparam int AES_NBYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 is the most significant byte of the 128-bit state.
    function automatic logic [6:0] byte_lsb(input int idx);
        return 7'((AES_NBYTES - 1 - idx) * 8);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box: purely combinational lookup into the shared table.
module inv_sbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_subbytes_engine.sv
// Inverse SubBytes engine: substitutes LANES bytes of the buffered state per cycle, valid/ready on both sides.
// Optional macro INV_SUBBYTES_BACK2BACK_EN: DONE may hand off the result and accept the next block in one cycle.
module inv_subbytes_engine
    import aes_dec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NBEAT = AES_NBYTES / LANES;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBEAT - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("inv_subbytes_engine: LANES=%0d must be one of 1,2,4,8,16", LANES);
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   buf_q, buf_d;
    logic [7:0]     lane_in_s  [LANES];
    logic [7:0]     lane_out_s [LANES];

    // Lane k reads buffer byte cnt*LANES+k.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in_s[k] = buf_q[byte_lsb(int'(cnt_q) * LANES + k) +: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        inv_sbox u_inv_sbox (
            .byte_i (lane_in_s[k]),
            .byte_o (lane_out_s[k])
        );
    end

    // Next-state, beat counter and in-place buffer update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                for (int k = 0; k < LANES; k++) begin
                    buf_d[byte_lsb(int'(cnt_q) * LANES + k) +: 8] = lane_out_s[k];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
`ifdef INV_SUBBYTES_BACK2BACK_EN
                if (out_ready && in_valid) begin
                    buf_d   = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
`else
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: in_ready = 1'b0;
            DONE: begin
                out_valid = 1'b1;
`ifdef INV_SUBBYTES_BACK2BACK_EN
                in_ready  = out_ready;
`else
                in_ready  = 1'b0;
`endif
            end
            default: in_ready = 1'b0;
        endcase
    end

    // State, counter and buffer registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign out_data = buf_q;

endmodule

// File: tb/tb_inv_subbytes_engine.sv
// Directed scoreboard bench for inv_subbytes_engine; the inverse S-box reference is derived from GF(2^8) arithmetic.
module tb_inv_subbytes_engine;

    parameter int LANES = 4;
    localparam int NBEAT = 16 / LANES;
`ifdef INV_SUBBYTES_BACK2BACK_EN
    localparam int EXP_GAP = NBEAT + 1;
`else
    localparam int EXP_GAP = NBEAT + 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    logic [7:0]   inv_tab [256];
    logic [127:0] sb [$];
    int           n_vec = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    inv_subbytes_engine #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = inv_tab[d[127 - 8 * i -: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64 && in_ready !== 1'b1; i++) @(negedge clk);
        chk("in_ready_wait", 128'(in_ready), 128'(1'b1));
    endtask

    task automatic run_block(input logic [127:0] d, input int hold, input string tag);
        int lat;
        logic [127:0] snap;
        out_ready = (hold == 0);
        wait_ready();
        in_data  = d;
        in_valid = 1'b1;
        sb.push_back(model(d));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(NBEAT));
        chk({tag, "_data"}, out_data, sb.pop_front());
        if (hold > 0) begin
            snap = out_data;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == 3);
                in_data  = ~d;
                @(negedge clk);
                chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1'b1));
                chk({tag, "_hold_data"}, out_data, snap);
                chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(1'b0));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_valid_drop"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_idle_ready"}, 128'(in_ready), 128'(1'b1));
    endtask

    task automatic run_b2b(input logic [127:0] a, input logic [127:0] b);
        int  t1 = -1;
        int  t2 = -1;
        int  nsent = 0;
        bit  acc;
        out_ready = 1'b1;
        wait_ready();
        in_data  = a;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && t2 < 0; c++) begin
            if (out_valid === 1'b1) begin
                chk("b2b_data", out_data, sb.pop_front());
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            if (acc) sb.push_back(model(in_data));
            @(posedge clk);
            #1;
            if (acc) begin
                nsent++;
                if (nsent == 1) in_data = b;
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_gap", 128'(t2 - t1), 128'(EXP_GAP));
        chk("b2b_sb_empty", 128'(sb.size()), 128'(0));
        @(negedge clk);
        @(negedge clk);
        chk("b2b_final_idle", 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        build_model();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        run_block({16{8'h63}}, 0, "s1_63");
        run_block({16{8'h00}}, 0, "s2_00");
        run_block({16{8'h16}}, 0, "s2_16");
        run_block({16{8'h7c}}, 0, "s2_7c");
        run_block({8'h63, 8'h7c, 112'h0}, 0, "s2_order");

        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) d[127 - 8 * i -: 8] = 8'(blk * 16 + i);
            run_block(d, 0, "sweep");
        end

        run_block(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 10, "s3_hold");

        out_ready = 1'b1;
        wait_ready();
        in_data  = {16{8'h5a}};
        in_valid = 1'b1;
        sb.push_back(model(in_data));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s4_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("s4_rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("s4_rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        void'(sb.pop_back());
        run_block({16{8'h63}}, 0, "s4_after_rst");

        run_b2b(128'h00112233_44556677_8899aabb_ccddeeff, 128'h637c0016_52090a0b_fedcba98_7c7c6363);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
